ft2232h_rx_ctrl: RTL and testbench

//  Read sequencer for the FT2232H FIFO receive port (FT245 async mode). Watches RXF#,

---
 rtl/ft2232h_rx_ctrl.sv | 106 ++++++++++
 tb/tb_ft2232h_rx_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft2232h_rx_ctrl.sv
// FT2232H FT245-async receive sequencer: synchronizes RXF#, issues timed RD# strobes,
// captures one byte per strobe and holds it on a valid/ready output register.
module ft2232h_rx_ctrl #(
  parameter int RD_LOW_CYC  = 3,
  parameter int RD_HIGH_CYC = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             ft_rxf_n_i,
  input  logic [7:0]       ft_data_i,
  output logic             ft_rd_n_o,
  output logic [7:0]       rx_data_o,
  output logic             rx_valid_o,
  input  logic             rx_ready_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] rx_count_o
);

  typedef enum logic [1:0] {IDLE, STROBE, PRECHARGE} state_t;

  localparam int CMAX = (RD_LOW_CYC > RD_HIGH_CYC) ? RD_LOW_CYC : RD_HIGH_CYC;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] LOW_LAST  = CW'(RD_LOW_CYC - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(RD_HIGH_CYC - 1);

  state_t                 state, state_nxt;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] rxf_sync;
  logic                   rxf_s;
  logic                   capture;
  logic                   rd_n_nxt;

  // Chain resets to all-ones so RXF# reads as empty until genuinely sampled low
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rxf_sync <= '1;
    else          rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], ft_rxf_n_i};
  end
  assign rxf_s = rxf_sync[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en_i && !rxf_s && !rx_valid_o) state_nxt = STROBE;
      end
      STROBE: begin
        if (cnt == LOW_LAST) begin
          state_nxt = PRECHARGE;
          cnt_nxt   = '0;
        end
      end
      PRECHARGE: begin
        if (cnt == HIGH_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // RD# is registered from the next state so it is low exactly while in STROBE
  always_comb begin
    capture  = (state == STROBE) && (cnt == LOW_LAST);
    rd_n_nxt = (state_nxt != STROBE);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ft_rd_n_o  <= 1'b1;
      rx_data_o  <= '0;
      rx_valid_o <= 1'b0;
      rx_count_o <= '0;
    end else begin
      ft_rd_n_o <= rd_n_nxt;
      if (capture) begin
        rx_data_o  <= ft_data_i;
        rx_valid_o <= 1'b1;
        rx_count_o <= rx_count_o + 1'b1;
      end else if (rx_valid_o && rx_ready_i) begin
        rx_valid_o <= 1'b0;
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_ft2232h_rx_ctrl.sv
// Bench for ft2232h_rx_ctrl: an FT2232H FIFO model feeds bytes, a scoreboard checks
// delivered data, and per-scenario tasks check strobe timing, backpressure and reset.
module tb_ft2232h_rx_ctrl;
  localparam int CW_TB = 5;
  localparam int LOWC  = 3;
  localparam int HIGHC = 4;

  logic             clk = 1'b0;
  logic             rst_n_i = 1'b0;
  logic             en_i = 1'b0;
  logic             ft_rxf_n_i;
  logic [7:0]       ft_data_i = 8'h00;
  logic             ft_rd_n_o;
  logic [7:0]       rx_data_o;
  logic             rx_valid_o;
  logic             rx_ready_i = 1'b0;
  logic             busy_o;
  logic [CW_TB-1:0] rx_count_o;

  ft2232h_rx_ctrl #(.RD_LOW_CYC(LOWC), .RD_HIGH_CYC(HIGHC), .SYNC_STAGES(2), .CNT_W(CW_TB)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .en_i(en_i), .ft_rxf_n_i(ft_rxf_n_i),
    .ft_data_i(ft_data_i), .ft_rd_n_o(ft_rd_n_o), .rx_data_o(rx_data_o),
    .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i), .busy_o(busy_o),
    .rx_count_o(rx_count_o)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] mem [64];
  int         n_bytes = 0;
  int         ptr = 0;
  logic       rxf_gate = 1'b0;
  logic [7:0] sb [$];
  int         exp_cnt = 0;
  int         lowc = 0;
  int         highc = 100;

  // FIFO model: RXF# low while bytes remain; byte presented on RD# fall, popped on RD# rise
  assign ft_rxf_n_i = rxf_gate | (ptr >= n_bytes);

  always @(negedge ft_rd_n_o) begin
    if (rst_n_i) begin
      n_tests++;
      if (ptr >= n_bytes) begin
        n_fail++;
        $display("FAIL extra_strobe: strobe with %0d bytes left, required none", n_bytes - ptr);
      end else begin
        ft_data_i = mem[ptr];
        sb.push_back(mem[ptr]);
      end
    end
  end

  always @(posedge ft_rd_n_o) begin
    if (rst_n_i && ptr < n_bytes) ptr++;
  end

  // Monitor: scoreboard pops on handshake, RD# low/high widths checked
  always @(negedge clk) begin
    logic [7:0] exp;
    if (!rst_n_i) begin
      lowc  = 0;
      highc = 100;
    end else begin
      if (rx_valid_o && rx_ready_i) begin
        n_tests++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected: got %h, required no byte", rx_data_o);
        end else begin
          exp = sb.pop_front();
          if (rx_data_o !== exp) begin
            n_fail++;
            $display("FAIL sb_data: got %h, required %h", rx_data_o, exp);
          end
        end
      end
      if (ft_rd_n_o === 1'b0) begin
        if (lowc == 0) begin
          n_tests++;
          if (highc < HIGHC) begin
            n_fail++;
            $display("FAIL rd_high_width: got %0d, required >=%0d", highc, HIGHC);
          end
        end
        lowc++;
      end else begin
        if (lowc != 0) begin
          n_tests++;
          if (lowc != LOWC) begin
            n_fail++;
            $display("FAIL rd_low_width: got %0d, required %0d", lowc, LOWC);
          end
        end
        lowc = 0;
        highc++;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int got, input int req);
    n_tests++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic add_byte(input logic [7:0] b);
    mem[n_bytes] = b;
    n_bytes++;
  endtask

  task automatic wait_rd_low(input string name);
    int i;
    for (i = 0; i < 100 && ft_rd_n_o !== 1'b0; i++) tick();
    n_tests++;
    if (ft_rd_n_o !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: timeout waiting RD# low, got %b required 0", name, ft_rd_n_o);
    end
  endtask

  task automatic wait_idle(input string name, input int limit);
    int i;
    for (i = 0; i < limit && !(sb.size() == 0 && ptr == n_bytes && !busy_o && !rx_valid_o); i++)
      tick();
    n_tests++;
    if (!(sb.size() == 0 && ptr == n_bytes && !busy_o && !rx_valid_o)) begin
      n_fail++;
      $display("FAIL %s: timeout, %0d pending bytes %0d queued, required 0", name,
               n_bytes - ptr, sb.size());
    end
  endtask

  task automatic test_reset;
    add_byte(8'hA5);
    rxf_gate = 1'b0;
    rst_n_i  = 1'b0;
    repeat (5) tick();
    chk("reset_rd_n", int'(ft_rd_n_o), 1);
    chk("reset_valid", int'(rx_valid_o), 0);
    chk("reset_count", int'(rx_count_o), 0);
    chk("reset_busy", int'(busy_o), 0);
    rxf_gate = 1'b1;
    tick();
    rst_n_i = 1'b1;
    en_i = 1'b1;
    rx_ready_i = 1'b1;
    repeat (4) tick();
    chk("idle_no_strobe", int'(ft_rd_n_o), 1);
  endtask

  task automatic test_single;
    tick();
    rxf_gate = 1'b0;
    tick(); tick();
    chk("single_rd_early", int'(ft_rd_n_o), 1);
    tick();
    chk("single_rd_fall", int'(ft_rd_n_o), 0);
    tick(); tick();
    chk("single_rd_still_low", int'(ft_rd_n_o), 0);
    tick();
    chk("single_rd_rise", int'(ft_rd_n_o), 1);
    chk("single_valid", int'(rx_valid_o), 1);
    chk("single_data", int'(rx_data_o), 8'hA5);
    tick();
    chk("single_valid_clr", int'(rx_valid_o), 0);
    exp_cnt += 1;
    chk("single_count", int'(rx_count_o), exp_cnt % 32);
    wait_idle("single_idle", 50);
  endtask

  task automatic test_back_to_back;
    int falls[$];
    logic prev;
    int bad;
    for (int i = 0; i < 16; i++) add_byte(8'(i + 1));
    prev = ft_rd_n_o;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (prev && !ft_rd_n_o) falls.push_back(c);
      prev = ft_rd_n_o;
    end
    chk("burst_strobes", falls.size(), 16);
    bad = 0;
    for (int i = 1; i < falls.size(); i++) if (falls[i] - falls[i-1] != 8) bad++;
    chk("burst_period_8", bad, 0);
    wait_idle("burst_idle", 50);
    exp_cnt += 16;
    chk("burst_count", int'(rx_count_o), exp_cnt % 32);
  endtask

  task automatic test_backpressure;
    int bad;
    int i;
    rx_ready_i = 1'b0;
    add_byte(8'hAA); add_byte(8'hBB); add_byte(8'hCC);
    for (i = 0; i < 60 && rx_valid_o !== 1'b1; i++) tick();
    chk("bp_first_valid", int'(rx_valid_o), 1);
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (ft_rd_n_o !== 1'b1 || rx_valid_o !== 1'b1 || rx_data_o !== 8'hAA) bad++;
    end
    chk("bp_hold_50", bad, 0);
    chk("bp_no_extra_pop", ptr, n_bytes - 2);
    rx_ready_i = 1'b1;
    tick();
    chk("bp_accept_clr", int'(rx_valid_o), 0);
    chk("bp_accept_rd_high", int'(ft_rd_n_o), 1);
    tick();
    chk("bp_next_strobe", int'(ft_rd_n_o), 0);
    wait_idle("bp_idle", 100);
    exp_cnt += 3;
    chk("bp_count", int'(rx_count_o), exp_cnt % 32);
  endtask

  task automatic test_en_mid_strobe;
    int falls;
    logic prev;
    for (int i = 0; i < 4; i++) add_byte(8'(8'h30 + i));
    wait_rd_low("en_wait");
    tick();
    en_i = 1'b0;
    falls = 0;
    prev = ft_rd_n_o;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (prev && !ft_rd_n_o) falls++;
      prev = ft_rd_n_o;
    end
    chk("en_no_strobes", falls, 0);
    chk("en_byte_delivered", sb.size(), 0);
    chk("en_count", int'(rx_count_o), (exp_cnt + 1) % 32);
    en_i = 1'b1;
    wait_idle("en_idle", 100);
    exp_cnt += 4;
    chk("en_count_final", int'(rx_count_o), exp_cnt % 32);
  endtask

  task automatic test_reset_mid;
    add_byte(8'h5A); add_byte(8'hC3);
    wait_rd_low("rst_wait");
    tick();
    rst_n_i = 1'b0;
    #1;
    chk("rstmid_rd_n", int'(ft_rd_n_o), 1);
    chk("rstmid_valid", int'(rx_valid_o), 0);
    chk("rstmid_count", int'(rx_count_o), 0);
    chk("rstmid_busy", int'(busy_o), 0);
    chk("rstmid_partial_queued", sb.size(), 1);
    sb.delete();
    exp_cnt = 0;
    repeat (3) tick();
    rst_n_i = 1'b1;
    wait_idle("rstmid_idle", 100);
    exp_cnt += 2;
    chk("rstmid_count_resume", int'(rx_count_o), exp_cnt % 32);
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 31; i++) add_byte(8'($urandom_range(0, 255)));
    wait_idle("wrap_idle", 400);
    exp_cnt += 31;
    chk("wrap_count", int'(rx_count_o), exp_cnt % 32);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_en_mid_strobe();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
